// File: rtl/vgatext_console_pkg.sv
// Shared constants, control codes and state encoding for the vgatext console writer.
// VGATEXT_CONSOLE_CLS_EN adds the CLRALL state (form feed / power-up screen clear).
package vgatext_console_pkg;

  localparam int          DEF_COLS  = 80;
  localparam int          DEF_ROWS  = 37;
  localparam logic [7:0]  DEF_BLANK = 8'h20;

  localparam int CUR_X_W = 7;
  localparam int CUR_Y_W = 6;
  localparam int ADDR_W  = 12;

  localparam logic [7:0] CC_BS  = 8'h08;
  localparam logic [7:0] CC_TAB = 8'h09;
  localparam logic [7:0] CC_LF  = 8'h0A;
  localparam logic [7:0] CC_FF  = 8'h0C;
  localparam logic [7:0] CC_CR  = 8'h0D;
  localparam logic [7:0] CC_DEL = 8'h7F;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
`ifdef VGATEXT_CONSOLE_CLS_EN
    ST_CLRLINE = 2'd1,
    ST_CLRALL  = 2'd2
`else
    ST_CLRLINE = 2'd1
`endif
  } state_e;

  // Everything from space upward except DEL, including the upper half.
  function automatic logic is_printable(input logic [7:0] b);
    return (b >= 8'h20) && (b != CC_DEL);
  endfunction

endpackage

// File: rtl/vgatext_console_addr_gen.sv
// Text-memory address generator: row*COLS + col, shift-add when COLS is 80.
module vgatext_console_addr_gen
  import vgatext_console_pkg::*;
#(
  parameter int COLS = DEF_COLS
) (
  input  logic [CUR_Y_W-1:0] row_i,
  input  logic [CUR_X_W-1:0] col_i,
  output logic [ADDR_W-1:0]  addr_o
);

  if (COLS == 80) begin : g_shift
    assign addr_o = (ADDR_W'(row_i) << 6) + (ADDR_W'(row_i) << 4) + ADDR_W'(col_i);
  end else begin : g_mul
    assign addr_o = ADDR_W'(row_i) * ADDR_W'(COLS) + ADDR_W'(col_i);
  end

endmodule

// File: rtl/vgatext_console.sv
// Console byte-stream writer for the vgatext buffer: decodes bytes, tracks the cursor,
// clears rows on newline. VGATEXT_CONSOLE_CLS_EN enables form-feed/power-up full clear.
//
//  state      | meaning
//  IDLE       | ready for a byte, decodes and writes on accept
//  CLRLINE    | blanking current row, one cell per cycle
//  CLRALL     | blanking whole screen (CLS build only)
module vgatext_console
  import vgatext_console_pkg::*;
#(
  parameter int         COLS  = DEF_COLS,
  parameter int         ROWS  = DEF_ROWS,
  parameter logic [7:0] BLANK = DEF_BLANK
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic [7:0]         char_data_i,
  input  logic               char_valid_i,
  output logic               char_ready_o,
  output logic [ADDR_W-1:0]  wr_addr_o,
  output logic               wr_en_o,
  output logic [7:0]         wr_data_o,
  output logic [CUR_X_W-1:0] cur_x_o,
  output logic [CUR_Y_W-1:0] cur_y_o,
  output logic               busy_o
);

  state_e               state_q, state_d;
  logic [CUR_X_W-1:0]   cur_x_q, cur_x_d;
  logic [CUR_Y_W-1:0]   cur_y_q, cur_y_d;
  logic [ADDR_W-1:0]    clr_cnt_q, clr_cnt_d;
  logic                 wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]    wr_addr_q, wr_addr_d;
  logic [7:0]           wr_data_q, wr_data_d;
  logic                 ready_q, ready_d;
  logic                 busy_q, busy_d;

  logic                 accept, is_print, is_cr, is_lf, is_bs, is_tab;
  logic                 x_last, y_last, tab_over, newline;
  logic [7:0]           tab_x;
  logic [CUR_X_W-1:0]   gen_col;
  logic [ADDR_W-1:0]    gen_addr;
`ifdef VGATEXT_CONSOLE_CLS_EN
  logic                 is_ff;
  assign is_ff = (char_data_i == CC_FF);
`endif

  assign accept   = char_valid_i & ready_q;
  assign is_print = is_printable(char_data_i);
  assign is_cr    = (char_data_i == CC_CR);
  assign is_lf    = (char_data_i == CC_LF);
  assign is_bs    = (char_data_i == CC_BS);
  assign is_tab   = (char_data_i == CC_TAB);
  assign x_last   = (cur_x_q == CUR_X_W'(COLS - 1));
  assign y_last   = (cur_y_q == CUR_Y_W'(ROWS - 1));
  assign tab_x    = {1'b0, cur_x_q | 7'd7} + 8'd1;
  assign tab_over = (tab_x >= 8'(COLS));
  assign newline  = is_lf | (is_print & x_last) | (is_tab & tab_over);

  // Backspace targets the cell left of the cursor; the clear walks the counter.
  assign gen_col = (state_q == ST_CLRLINE) ? clr_cnt_q[CUR_X_W-1:0]
                 : (is_bs ? cur_x_q - 7'd1 : cur_x_q);

  vgatext_console_addr_gen #(.COLS(COLS)) u_addr_gen (
    .row_i  (cur_y_q),
    .col_i  (gen_col),
    .addr_o (gen_addr)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
`ifdef VGATEXT_CONSOLE_CLS_EN
      state_q <= ST_CLRALL;
`else
      state_q <= ST_IDLE;
`endif
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept && newline) state_d = ST_CLRLINE;
`ifdef VGATEXT_CONSOLE_CLS_EN
        else if (accept && is_ff) state_d = ST_CLRALL;
`endif
      end
      ST_CLRLINE: if (clr_cnt_q == ADDR_W'(COLS - 1)) state_d = ST_IDLE;
`ifdef VGATEXT_CONSOLE_CLS_EN
      ST_CLRALL:  if (clr_cnt_q == ADDR_W'(ROWS * COLS - 1)) state_d = ST_IDLE;
`endif
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cur_x_d   = cur_x_q;
    cur_y_d   = cur_y_q;
    clr_cnt_d = clr_cnt_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (newline) begin
            cur_x_d   = '0;
            cur_y_d   = y_last ? '0 : cur_y_q + 6'd1;
            clr_cnt_d = '0;
          end
          if (is_print) begin
            wr_en_d   = 1'b1;
            wr_addr_d = gen_addr;
            wr_data_d = char_data_i;
            if (!x_last) cur_x_d = cur_x_q + 7'd1;
          end else if (is_cr) begin
            cur_x_d = '0;
          end else if (is_bs && cur_x_q != '0) begin
            wr_en_d   = 1'b1;
            wr_addr_d = gen_addr;
            wr_data_d = BLANK;
            cur_x_d   = cur_x_q - 7'd1;
          end else if (is_tab && !tab_over) begin
            cur_x_d = tab_x[CUR_X_W-1:0];
          end
`ifdef VGATEXT_CONSOLE_CLS_EN
          else if (is_ff) begin
            cur_x_d   = '0;
            cur_y_d   = '0;
            clr_cnt_d = '0;
          end
`endif
        end
      end
      ST_CLRLINE: begin
        wr_en_d   = 1'b1;
        wr_addr_d = gen_addr;
        wr_data_d = BLANK;
        clr_cnt_d = clr_cnt_q + 12'd1;
      end
`ifdef VGATEXT_CONSOLE_CLS_EN
      ST_CLRALL: begin
        wr_en_d   = 1'b1;
        wr_addr_d = clr_cnt_q;
        wr_data_d = BLANK;
        clr_cnt_d = clr_cnt_q + 12'd1;
      end
`endif
      default: ;
    endcase
  end

  assign ready_d = (state_d == ST_IDLE);
  assign busy_d  = ~ready_d;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cur_x_q   <= '0;
      cur_y_q   <= '0;
      clr_cnt_q <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      cur_x_q   <= cur_x_d;
      cur_y_q   <= cur_y_d;
      clr_cnt_q <= clr_cnt_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
    end
  end

  assign char_ready_o = ready_q;
  assign busy_o       = busy_q;
  assign wr_en_o      = wr_en_q;
  assign wr_addr_o    = wr_addr_q;
  assign wr_data_o    = wr_data_q;
  assign cur_x_o      = cur_x_q;
  assign cur_y_o      = cur_y_q;

endmodule

// File: tb/tb_vgatext_console.sv
// Directed bench for vgatext_console: printable/control decode, wrap, row clears,
// and (with VGATEXT_CONSOLE_CLS_EN) full-screen clear and mid-clear reset.
module tb_vgatext_console;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  data = 8'h00;
  logic        valid = 1'b0;
  logic        ready, wr_en, busy;
  logic [11:0] wr_addr;
  logic [7:0]  wr_data;
  logic [6:0]  cur_x;
  logic [5:0]  cur_y;

  int vec = 0;
  int err = 0;

  always #5 clk = ~clk;

  vgatext_console dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .char_data_i  (data),
    .char_valid_i (valid),
    .char_ready_o (ready),
    .wr_addr_o    (wr_addr),
    .wr_en_o      (wr_en),
    .wr_data_o    (wr_data),
    .cur_x_o      (cur_x),
    .cur_y_o      (cur_y),
    .busy_o       (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp)
    else begin
      err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called on a falling edge; returns on the falling edge after the accepting edge.
  task automatic send(input logic [7:0] b);
    int n = 0;
    while (!ready && n < 4000) begin
      @(negedge clk);
      n++;
    end
    chk("send_ready", 32'(ready), 32'd1);
    data  = b;
    valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
  endtask

  // Samples from the current falling edge; expects n blank writes at base, base+1, ...
  task automatic clr_check(input int base, input int n, input bit char_first);
    int low = 0;
    int nw  = 0;
    int bad = 0;
    for (int i = 0; i < n + 40; i++) begin
      if (!ready) low++;
      if (wr_en && !(i == 0 && char_first)) begin
        if (wr_addr !== 12'(base + nw) || wr_data !== 8'h20) bad++;
        nw++;
      end
      if (nw == n) break;
      @(negedge clk);
    end
    chk("clr_writes", 32'(nw), 32'(n));
    chk("clr_bad_cells", 32'(bad), 32'd0);
    chk("clr_ready_low", 32'(low), 32'(n));
  endtask

  initial begin
    // reset state
    repeat (3) @(negedge clk);
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cur", {cur_y, cur_x}, 32'd0);
    chk("rst_addr", 32'(wr_addr), 32'd0);
    rst_n = 1'b1;
`ifdef VGATEXT_CONSOLE_CLS_EN
    clr_check(0, 2960, 1'b0);
`else
    chk("rel_ready_before_edge", 32'(ready), 32'd0);
    @(negedge clk);
    chk("rel_ready", 32'(ready), 32'd1);
    chk("rel_busy", 32'(busy), 32'd0);
`endif

    // 'A' at home
    send(8'h41);
    chk("A_wr_en", 32'(wr_en), 32'd1);
    chk("A_addr", 32'(wr_addr), 32'd0);
    chk("A_data", 32'(wr_data), 32'h41);
    chk("A_cur", {cur_y, cur_x}, {19'd0, 6'd0, 7'd1});
    @(negedge clk);
    chk("A_single_strobe", 32'(wr_en), 32'd0);

    send(8'h0D);
    chk("CR_no_write", 32'(wr_en), 32'd0);
    chk("CR_x", 32'(cur_x), 32'd0);

    // walk to column 79 of row 0
    send(8'h09);
    chk("TAB0_x", 32'(cur_x), 32'd8);
    repeat (8) send(8'h09);
    chk("TAB72_x", 32'(cur_x), 32'd72);
    repeat (7) send(8'h62);
    chk("col79", {cur_y, cur_x}, {19'd0, 6'd0, 7'd79});

    // 'Z' at last column: char write, wrap, clear row 1 while a byte is held
    send(8'h5A);
    chk("Z_wr_en", 32'(wr_en), 32'd1);
    chk("Z_addr", 32'(wr_addr), 32'd79);
    chk("Z_data", 32'(wr_data), 32'h5A);
    chk("Z_cur", {cur_y, cur_x}, {19'd0, 6'd1, 7'd0});
    data  = 8'h51;
    valid = 1'b1;
    clr_check(80, 80, 1'b1);
    chk("held_not_taken", {cur_y, cur_x}, {19'd0, 6'd1, 7'd0});
    @(negedge clk);
    valid = 1'b0;
    chk("held_wr_en", 32'(wr_en), 32'd1);
    chk("held_addr", 32'(wr_addr), 32'd80);
    chk("held_data", 32'(wr_data), 32'h51);
    chk("held_x", 32'(cur_x), 32'd1);

    // tabs and ignored controls on row 1
    send(8'h0D);
    send(8'h78); send(8'h79); send(8'h7A);
    chk("xyz_x", 32'(cur_x), 32'd3);
    send(8'h09);
    chk("TAB3_x", 32'(cur_x), 32'd8);
    chk("TAB3_no_write", 32'(wr_en), 32'd0);
    send(8'h07);
    chk("BEL_no_write", 32'(wr_en), 32'd0);
    chk("BEL_cur", {cur_y, cur_x}, {19'd0, 6'd1, 7'd8});
    send(8'h7F);
    chk("DEL_no_write", 32'(wr_en), 32'd0);
    chk("DEL_cur", {cur_y, cur_x}, {19'd0, 6'd1, 7'd8});
`ifndef VGATEXT_CONSOLE_CLS_EN
    send(8'h0C);
    chk("FF_ignored_no_write", 32'(wr_en), 32'd0);
    chk("FF_ignored_cur", {cur_y, cur_x}, {19'd0, 6'd1, 7'd8});
    chk("FF_ignored_ready", 32'(ready), 32'd1);
`endif
    repeat (8) send(8'h09);
    chk("TAB_row1_72", 32'(cur_x), 32'd72);
    send(8'hC8);
    chk("hi_byte_addr", 32'(wr_addr), 32'd152);
    chk("hi_byte_data", 32'(wr_data), 32'hC8);
    repeat (5) send(8'h63);
    chk("col78", 32'(cur_x), 32'd78);
    send(8'h09);
    chk("TAB78_cur", {cur_y, cur_x}, {19'd0, 6'd2, 7'd0});
    chk("TAB78_no_write", 32'(wr_en), 32'd0);
    chk("TAB78_busy", 32'(busy), 32'd1);
    clr_check(160, 80, 1'b0);

    // backspace on row 2
    repeat (5) send(8'h61);
    chk("a5_addr", 32'(wr_addr), 32'd164);
    chk("a5_x", 32'(cur_x), 32'd5);
    send(8'h08);
    chk("BS_wr_en", 32'(wr_en), 32'd1);
    chk("BS_addr", 32'(wr_addr), 32'd164);
    chk("BS_data", 32'(wr_data), 32'h20);
    chk("BS_x", 32'(cur_x), 32'd4);
    send(8'h0D);
    send(8'h08);
    chk("BS0_no_write", 32'(wr_en), 32'd0);
    chk("BS0_cur", {cur_y, cur_x}, {19'd0, 6'd2, 7'd0});

    // line feeds down to the last row, then wrap to row 0
    for (int r = 3; r <= 36; r++) begin
      send(8'h0A);
      clr_check(r * 80, 80, 1'b0);
    end
    chk("row36", {cur_y, cur_x}, {19'd0, 6'd36, 7'd0});
    send(8'h0A);
    chk("LF_wrap_cur", {cur_y, cur_x}, 32'd0);
    chk("LF_wrap_no_write", 32'(wr_en), 32'd0);
    clr_check(0, 80, 1'b0);

`ifdef VGATEXT_CONSOLE_CLS_EN
    send(8'h0A);
    clr_check(80, 80, 1'b0);
    send(8'h09);
    send(8'h0C);
    chk("FF_cur", {cur_y, cur_x}, 32'd0);
    chk("FF_no_write", 32'(wr_en), 32'd0);
    clr_check(0, 2960, 1'b0);
    send(8'h09);
    send(8'h0C);
    begin
      int nw = 0;
      for (int i = 0; i < 200 && nw < 100; i++) begin
        @(negedge clk);
        if (wr_en) nw++;
      end
      chk("FF_partial_writes", 32'(nw), 32'd100);
      chk("FF_write100_addr", 32'(wr_addr), 32'd99);
    end
    rst_n = 1'b0;
    #1;
    chk("abort_wr_en", 32'(wr_en), 32'd0);
    chk("abort_cur", {cur_y, cur_x}, 32'd0);
    chk("abort_ready", 32'(ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    clr_check(0, 2960, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
